// File: rtl/button_event_arbiter.sv
// Shared-prescaler debouncer for N_BTN buttons with a one-deep pending slot per button/event type
// and a round-robin valid/ready event output. Define BUTTON_EVT_LONG_EN to add long-press events.
module button_event_arbiter #(
  parameter int N_BTN        = 4,
  parameter int TICK_CLOCKS  = 10_000,
  parameter int STABLE_TICKS = 100,
  parameter int LONG_TICKS   = 1000
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [N_BTN-1:0]                           btn_i,
  output logic [N_BTN-1:0]                           level_o,
  output logic                                       evt_valid_o,
  input  logic                                       evt_ready_i,
  output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] evt_id_o,
  output logic [1:0]                                 evt_type_o,
  output logic                                       overflow_o
);

  localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int PW  = $clog2(TICK_CLOCKS);
  localparam int CW  = $clog2(STABLE_TICKS + 1);
`ifdef BUTTON_EVT_LONG_EN
  localparam int NT  = 3;
  localparam int HW  = $clog2(LONG_TICKS + 1);
`else
  localparam int NT  = 2;
`endif
  // Pend bit index equals the emitted type code: press=0, release=1, long=2.
  localparam int T_PRESS = 0;
  localparam int T_REL   = 1;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [NT-1:0]    pend_q [N_BTN];
  logic [NT-1:0]    pend_d [N_BTN];
  logic [NT-1:0]    raise [N_BTN];
  logic [NT-1:0]    grant_clr [N_BTN];
`ifdef BUTTON_EVT_LONG_EN
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
`endif
  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d, rr_q, rr_d;
  logic [1:0]       type_q, type_d;
  logic             overflow_q, overflow_d;
  logic             load, found;
  logic [IDW-1:0]   gnt, idx;
  logic [1:0]       gnt_type;

  assign tick = (presc_q == PW'(TICK_CLOCKS - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      raise[i]   = '0;
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
          level_d[i] = ~level_q[i];
          cnt_d[i]   = '0;
          if (level_q[i]) raise[i][T_REL] = 1'b1;
          else            raise[i][T_PRESS] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
`ifdef BUTTON_EVT_LONG_EN
      // Saturating at LONG_TICKS guarantees a single long event per press.
      hold_d[i] = hold_q[i];
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] != HW'(LONG_TICKS)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_q[i] == HW'(LONG_TICKS - 1)) raise[i][2] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    load     = !valid_q || evt_ready_i;
    found    = 1'b0;
    gnt      = '0;
    idx      = '0;
    gnt_type = 2'b00;
    for (int k = 0; k < N_BTN; k++) begin
      idx = IDW'((int'(rr_q) + k) % N_BTN);
      if (!found && (|pend_q[idx])) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    if (pend_q[gnt][T_PRESS]) gnt_type = 2'b00;
`ifdef BUTTON_EVT_LONG_EN
    else if (pend_q[gnt][2]) gnt_type = 2'b10;
`endif
    else gnt_type = 2'b01;

    valid_d    = valid_q;
    id_d       = id_q;
    type_d     = type_q;
    rr_d       = rr_q;
    overflow_d = 1'b0;
    for (int i = 0; i < N_BTN; i++) grant_clr[i] = '0;
    if (load) begin
      valid_d = found;
      if (found) begin
        id_d   = gnt;
        type_d = gnt_type;
        rr_d   = IDW'((int'(gnt) + 1) % N_BTN);
        grant_clr[gnt][gnt_type] = 1'b1;
      end
    end
    // A bit freed by this cycle's grant absorbs a new event without overflow.
    for (int i = 0; i < N_BTN; i++) begin
      pend_d[i]  = (pend_q[i] & ~grant_clr[i]) | raise[i];
      overflow_d = overflow_d | (|(raise[i] & pend_q[i] & ~grant_clr[i]));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      type_q     <= 2'b00;
      rr_q       <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
`ifdef BUTTON_EVT_LONG_EN
        hold_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      type_q     <= type_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]  <= cnt_d[i];
        pend_q[i] <= pend_d[i];
`ifdef BUTTON_EVT_LONG_EN
        hold_q[i] <= hold_d[i];
`endif
      end
    end
  end

  assign level_o     = level_q;
  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign evt_type_o  = type_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Randomized bench for button_event_arbiter: a behavioural model of debounce, pending slots and
// round-robin output is stepped per clock and compared against the DUT every cycle.
module tb_button_event_arbiter;

  localparam int N_BTN        = 4;
  localparam int TICK_CLOCKS  = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 5;
`ifdef BUTTON_EVT_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [1:0]       evt_id_o;
  logic [1:0]       evt_type_o;
  logic             overflow_o;

  button_event_arbiter #(
    .N_BTN(N_BTN), .TICK_CLOCKS(TICK_CLOCKS),
    .STABLE_TICKS(STABLE_TICKS), .LONG_TICKS(LONG_TICKS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i), .level_o(level_o),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_id_o(evt_id_o),
    .evt_type_o(evt_type_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state (values expected after the most recent clock edge).
  logic [N_BTN-1:0] m_sy1, m_sy2, m_lvl;
  int  m_pc;
  int  m_cnt  [N_BTN];
  int  m_hold [N_BTN];
  bit  m_pend [N_BTN][3];
  bit  m_vld, m_ovf;
  int  m_id, m_type, m_rr;
  int  n_evt [3];

  task automatic model_reset();
    m_sy1 = '0; m_sy2 = '0; m_lvl = '0; m_pc = 0;
    m_vld = 0; m_ovf = 0; m_id = 0; m_type = 0; m_rr = 0;
    for (int i = 0; i < N_BTN; i++) begin
      m_cnt[i] = 0; m_hold[i] = 0;
      for (int t = 0; t < 3; t++) m_pend[i][t] = 0;
    end
  endtask

  task automatic model_step(input logic [N_BTN-1:0] b, input bit rdy);
    bit tk;
    bit raised [N_BTN][3];
    logic [N_BTN-1:0] s;
    int prio [3];
    bit found, old_lvl;
    prio = '{0, 2, 1};
    tk = (m_pc == TICK_CLOCKS - 1);
    m_pc = (m_pc + 1) % TICK_CLOCKS;
    s = m_sy2; m_sy2 = m_sy1; m_sy1 = b;
    for (int i = 0; i < N_BTN; i++) begin
      for (int t = 0; t < 3; t++) raised[i][t] = 0;
      old_lvl = m_lvl[i];
      if (tk) begin
        if (s[i] == old_lvl) m_cnt[i] = 0;
        else if (m_cnt[i] == STABLE_TICKS - 1) begin
          m_lvl[i] = ~old_lvl;
          m_cnt[i] = 0;
          raised[i][old_lvl ? 1 : 0] = 1;
        end else m_cnt[i]++;
      end
      if (LONG_EN) begin
        if (!old_lvl) m_hold[i] = 0;
        else if (tk && m_hold[i] < LONG_TICKS) begin
          m_hold[i]++;
          if (m_hold[i] == LONG_TICKS) raised[i][2] = 1;
        end
      end
    end
    if (!m_vld || rdy) begin
      found = 0;
      for (int k = 0; k < N_BTN && !found; k++) begin
        int bi;
        bi = (m_rr + k) % N_BTN;
        for (int p = 0; p < 3 && !found; p++) begin
          if (m_pend[bi][prio[p]]) begin
            found = 1;
            m_pend[bi][prio[p]] = 0;
            m_id = bi; m_type = prio[p]; m_rr = (bi + 1) % N_BTN;
            n_evt[prio[p]]++;
          end
        end
      end
      m_vld = found;
    end
    m_ovf = 0;
    for (int i = 0; i < N_BTN; i++)
      for (int t = 0; t < 3; t++)
        if (raised[i][t]) begin
          if (m_pend[i][t]) m_ovf = 1;
          else m_pend[i][t] = 1;
        end
  endtask

  task automatic compare_all();
    chk("level", level_o, m_lvl);
    chk("valid", evt_valid_o, m_vld);
    if (m_vld) begin
      chk("id", evt_id_o, m_id);
      chk("type", evt_type_o, m_type);
    end
    chk("overflow", overflow_o, m_ovf);
  endtask

  logic [N_BTN-1:0] btn_r;
  int rem [N_BTN];
  int n_ovf = 0;

  // mode 0: clean holds, mode 1: bouncy, mode 2: mixed. Call at a negedge.
  task automatic run_phase(input int cycles, input int mode, input int rdy_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (rem[i] == 0) begin
          btn_r[i] = ~btn_r[i];
          if (mode == 1 || (mode == 2 && $urandom_range(3) == 0))
            rem[i] = $urandom_range(7, 1);
          else
            rem[i] = $urandom_range(90, 16);
        end
        rem[i]--;
      end
      btn_i = btn_r;
      evt_ready_i = ($urandom_range(99) < rdy_pct);
      model_step(btn_r, evt_ready_i);
      @(negedge clk_i);
      if (m_ovf) n_ovf++;
      compare_all();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    btn_i = '0;
    btn_r = '0;
    evt_ready_i = 1'b0;
    n_evt = '{0, 0, 0};
    for (int i = 0; i < N_BTN; i++) rem[i] = $urandom_range(20, 1);
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_level", level_o, 0);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_id", evt_id_o, 0);
    chk("rst_type", evt_type_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst_i = 1'b0;

    run_phase(1500, 0, 100);
    run_phase(800, 1, 100);
    run_phase(1500, 2, 50);
    run_phase(300, 0, 0);

    // Asynchronous reset mid-cycle while events are queued.
    #3 rst_i = 1'b1;
    #1;
    chk("arst_valid", evt_valid_o, 0);
    chk("arst_level", level_o, 0);
    chk("arst_ovf", overflow_o, 0);
    chk("arst_id", evt_id_o, 0);
    chk("arst_type", evt_type_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();
    rst_i = 1'b0;

    run_phase(1500, 2, 70);
    run_phase(600, 0, 10);
    run_phase(400, 0, 100);

    if (n_evt[0] == 0 || n_evt[1] == 0 || (LONG_EN && n_evt[2] == 0) || n_ovf == 0)
      $display("note: sparse coverage press=%0d release=%0d long=%0d ovf=%0d",
               n_evt[0], n_evt[1], n_evt[2], n_ovf);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
